alarma_panel: RTL and testbench

- Keypad control panel that drives the alarm block's enable (on), silence (rst) and door (puerta) inputs.
- Accepts a multi-digit PIN to arm and disarm.
- Runs an exit delay after arming and an entry delay when the door opens while armed.
- Locks out the keypad after repeated wrong codes.

---
 rtl/alarma_pkg.sv | 21 ++
 rtl/alarma_code_buf.sv | 57 +++++
 rtl/alarma_panel.sv | 158 +++++++++++++++
 tb/tb_alarma_panel.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarma_pkg.sv
// Shared types and constants for the alarm keypad panel.
package alarma_pkg;

    typedef enum logic [2:0] {
        DISARMED,
        EXIT_DELAY,
        ARMED,
        ENTRY_DELAY,
        ALARM
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarma_code_buf.sv
// PIN entry buffer: digits shift in LS-first so the first digit ends up in the MS nibble.
// match/fail are combinational and only meaningful on the ENTER cycle; an empty ENTER raises neither.
module alarma_code_buf
    import alarma_pkg::*;
#(
    parameter int                       CODE_DIGITS = 4,
    parameter logic [4*CODE_DIGITS-1:0] CODE        = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic       o_match,
    output logic       o_fail
);

    localparam int             CW       = $clog2(CODE_DIGITS + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CODE_DIGITS);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(CODE_DIGITS + 1);

    logic [4*CODE_DIGITS-1:0] r_buf;
    logic [CW-1:0]            r_cnt;
    logic [4*CODE_DIGITS-1:0] w_shift;
    logic                     w_digit;
    logic                     w_enter;
    logic                     w_flush;
    logic                     w_hit;

    assign w_digit = i_key_valid && (i_key_code <= 4'd9);
    assign w_enter = i_key_valid && (i_key_code == KEY_ENTER);
    assign w_flush = w_enter || (i_key_valid && (i_key_code == KEY_CLEAR));

    assign w_shift[3:0] = i_key_code;
    genvar gi;
    generate
        for (gi = 1; gi < CODE_DIGITS; gi++) begin : g_slot
            assign w_shift[4*gi +: 4] = r_buf[4*(gi-1) +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (w_digit) begin
            r_buf <= w_shift;
            if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // Overlong entries (count saturated above CODE_DIGITS) can never match.
    assign w_hit   = (r_cnt == CNT_FULL) && (r_buf == CODE);
    assign o_match = w_enter && w_hit;
    assign o_fail  = w_enter && (r_cnt != '0) && !w_hit;

endmodule

// File: rtl/alarma_panel.sv
// Keypad control panel: PIN arm/disarm, exit/entry delays, wrong-code lockout.
// All outputs registered; a key shows its effect on the cycle after key_valid.
module alarma_panel
    import alarma_pkg::*;
#(
    parameter int                       CODE_DIGITS = 4,
    parameter logic [4*CODE_DIGITS-1:0] CODE        = 16'h1234,
    parameter int                       EXIT_CYC    = 1000,
    parameter int                       ENTRY_CYC   = 500,
    parameter int                       MAX_FAIL    = 3,
    parameter int                       LOCK_CYC    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       puerta_in,
    output logic       on,
    output logic       silence,
    output logic       puerta_o,
    output logic       exit_pend,
    output logic       entry_pend,
    output logic       locked,
    output logic [1:0] fail_cnt
);

    localparam int            TMAX       = max3(EXIT_CYC, ENTRY_CYC, LOCK_CYC);
    localparam int            TW         = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYC - 1);

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_exit_tmr, r_entry_tmr, r_lock_tmr;
    logic          r_locked;
    logic [1:0]    r_fail;
    logic          r_on, r_silence, r_puerta, r_exit, r_entry;
    logic          w_on_next, w_silence_next, w_puerta_next, w_exit_next, w_entry_next;
    logic          w_key_valid, w_match, w_fail;
    logic [1:0]    w_fail_inc;

    assign w_key_valid = key_valid && !r_locked;

    alarma_code_buf #(
        .CODE_DIGITS (CODE_DIGITS),
        .CODE        (CODE)
    ) u_code_buf (
        .clk         (clk),
        .rst         (rst),
        .i_key_valid (w_key_valid),
        .i_key_code  (key_code),
        .o_match     (w_match),
        .o_fail      (w_fail)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= DISARMED;
        else     r_state <= w_state_next;
    end

    // A match always wins over an expiring timer or a door event.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            DISARMED:    if (w_match) w_state_next = EXIT_DELAY;
            EXIT_DELAY:  if (w_match) w_state_next = DISARMED;
                         else if (r_exit_tmr == '0) w_state_next = ARMED;
            ARMED:       if (w_match) w_state_next = DISARMED;
                         else if (puerta_in) w_state_next = ENTRY_DELAY;
            ENTRY_DELAY: if (w_match) w_state_next = DISARMED;
                         else if (r_entry_tmr == '0) w_state_next = ALARM;
            ALARM:       if (w_match) w_state_next = DISARMED;
            default:     w_state_next = DISARMED;
        endcase
    end

    always_comb begin
        w_on_next     = 1'b0;
        w_exit_next   = 1'b0;
        w_entry_next  = 1'b0;
        w_puerta_next = puerta_in;
        unique case (w_state_next)
            EXIT_DELAY:  w_exit_next = 1'b1;
            ARMED:       begin w_on_next = 1'b1; w_puerta_next = 1'b0; end
            ENTRY_DELAY: begin w_on_next = 1'b1; w_entry_next = 1'b1; w_puerta_next = 1'b0; end
            ALARM:       begin w_on_next = 1'b1; w_puerta_next = 1'b1; end
            default:     ;
        endcase
        w_silence_next = w_match && (r_state == ARMED || r_state == ENTRY_DELAY || r_state == ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on      <= 1'b0;
            r_silence <= 1'b0;
            r_puerta  <= 1'b0;
            r_exit    <= 1'b0;
            r_entry   <= 1'b0;
        end else begin
            r_on      <= w_on_next;
            r_silence <= w_silence_next;
            r_puerta  <= w_puerta_next;
            r_exit    <= w_exit_next;
            r_entry   <= w_entry_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exit_tmr  <= '0;
            r_entry_tmr <= '0;
        end else begin
            if (r_state == DISARMED && w_match)
                r_exit_tmr <= EXIT_LOAD;
            else if (r_state == EXIT_DELAY && !w_match && r_exit_tmr != '0)
                r_exit_tmr <= r_exit_tmr - TW'(1);
            if (r_state == ARMED && w_state_next == ENTRY_DELAY)
                r_entry_tmr <= ENTRY_LOAD;
            else if (r_state == ENTRY_DELAY && !w_match && r_entry_tmr != '0)
                r_entry_tmr <= r_entry_tmr - TW'(1);
        end
    end

    assign w_fail_inc = r_fail + 2'd1;

    // Keys are gated while locked, so match/fail cannot fire during lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked   <= 1'b0;
            r_fail     <= 2'd0;
            r_lock_tmr <= '0;
        end else if (r_locked) begin
            if (r_lock_tmr == '0) begin
                r_locked <= 1'b0;
                r_fail   <= 2'd0;
            end else begin
                r_lock_tmr <= r_lock_tmr - TW'(1);
            end
        end else if (w_match) begin
            r_fail <= 2'd0;
        end else if (w_fail) begin
            r_fail <= w_fail_inc;
            if (w_fail_inc == 2'(MAX_FAIL)) begin
                r_locked   <= 1'b1;
                r_lock_tmr <= LOCK_LOAD;
            end
        end
    end

    assign on         = r_on;
    assign silence    = r_silence;
    assign puerta_o   = r_puerta;
    assign exit_pend  = r_exit;
    assign entry_pend = r_entry;
    assign locked     = r_locked;
    assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_alarma_panel.sv
// Self-checking bench: directed scenarios plus random transactions against a deadline-based model.
module tb_alarma_panel;

    localparam int          CODE_DIGITS = 4;
    localparam logic [15:0] CODE        = 16'h1234;
    localparam int          EXIT_CYC    = 8;
    localparam int          ENTRY_CYC   = 5;
    localparam int          MAX_FAIL    = 3;
    localparam int          LOCK_CYC    = 10;

    localparam int M_DIS = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       puerta_in = 1'b0;
    logic       on, silence, puerta_o, exit_pend, entry_pend, locked;
    logic [1:0] fail_cnt;

    alarma_panel #(
        .CODE_DIGITS (CODE_DIGITS),
        .CODE        (CODE),
        .EXIT_CYC    (EXIT_CYC),
        .ENTRY_CYC   (ENTRY_CYC),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYC    (LOCK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .puerta_in  (puerta_in),
        .on         (on),
        .silence    (silence),
        .puerta_o   (puerta_o),
        .exit_pend  (exit_pend),
        .entry_pend (entry_pend),
        .locked     (locked),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_edge   = 0;
    int n_txn    = 0;

    // Reference model: mode plus absolute deadlines (edge numbers) instead of countdowns.
    int  m_st = M_DIS;
    int  m_exit_end, m_entry_end, m_lock_end;
    int  m_fail = 0;
    bit  m_locked = 0;
    int  m_digits[$];
    bit  e_on, e_sil, e_puerta, e_exit, e_entry;
    int  sil_seen;
    bit  alarm_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n_edge);
        end
    endtask

    function automatic bit code_ok();
        logic [15:0] cv;
        cv = CODE;
        if (m_digits.size() != CODE_DIGITS) return 1'b0;
        for (int i = 0; i < CODE_DIGITS; i++)
            if (m_digits[i] != int'(cv[4*(CODE_DIGITS-1-i) +: 4])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit kv, input logic [3:0] kc, input bit door);
        bit mt;
        bit was_locked;
        mt = 1'b0;
        if (r) begin
            m_st = M_DIS; m_fail = 0; m_locked = 1'b0; m_digits.delete();
            e_on = 0; e_sil = 0; e_puerta = 0; e_exit = 0; e_entry = 0;
        end else begin
            was_locked = m_locked;
            if (m_locked && n_edge == m_lock_end) begin
                m_locked = 1'b0;
                m_fail   = 0;
            end
            if (kv && !was_locked) begin
                if (kc <= 4'd9) begin
                    m_digits.push_back(int'(kc));
                    if (m_digits.size() > CODE_DIGITS + 1) void'(m_digits.pop_front());
                end else if (kc == 4'hB) begin
                    m_digits.delete();
                end else if (kc == 4'hA) begin
                    if (m_digits.size() != 0) begin
                        if (code_ok()) begin
                            mt = 1'b1;
                            m_fail = 0;
                        end else begin
                            m_fail++;
                            if (m_fail >= MAX_FAIL) begin
                                m_locked   = 1'b1;
                                m_lock_end = n_edge + LOCK_CYC;
                            end
                        end
                    end
                    m_digits.delete();
                end
            end
            e_sil = 1'b0;
            case (m_st)
                M_DIS:   if (mt) begin m_st = M_EXIT; m_exit_end = n_edge + EXIT_CYC; end
                M_EXIT:  if (mt) m_st = M_DIS;
                         else if (n_edge == m_exit_end) m_st = M_ARMED;
                M_ARMED: if (mt) begin m_st = M_DIS; e_sil = 1'b1; end
                         else if (door) begin m_st = M_ENTRY; m_entry_end = n_edge + ENTRY_CYC; end
                M_ENTRY: if (mt) begin m_st = M_DIS; e_sil = 1'b1; end
                         else if (n_edge == m_entry_end) m_st = M_ALARM;
                default: if (mt) begin m_st = M_DIS; e_sil = 1'b1; end
            endcase
            e_on     = (m_st == M_ARMED || m_st == M_ENTRY || m_st == M_ALARM);
            e_exit   = (m_st == M_EXIT);
            e_entry  = (m_st == M_ENTRY);
            e_puerta = (m_st == M_DIS || m_st == M_EXIT) ? door : (m_st == M_ALARM);
        end
    endtask

    task automatic cycle(input bit r, input bit kv, input logic [3:0] kc, input bit door);
        rst = r; key_valid = kv; key_code = kc; puerta_in = door;
        model_step(r, kv, kc, door);
        @(posedge clk);
        n_edge++;
        #1;
        check_eq("on", on, e_on);
        check_eq("silence", silence, e_sil);
        check_eq("puerta_o", puerta_o, e_puerta);
        check_eq("exit_pend", exit_pend, e_exit);
        check_eq("entry_pend", entry_pend, e_entry);
        check_eq("locked", locked, m_locked);
        check_eq("fail_cnt", fail_cnt, m_fail);
        if (silence === 1'b1) sil_seen++;
        if (on === 1'b1 && puerta_o === 1'b1) alarm_seen = 1'b1;
        rst = 1'b0; key_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        cycle(1'b0, 1'b1, k, 1'b0);
    endtask

    task automatic idle(input int n, input bit door);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, door);
    endtask

    task automatic enter_seq(input logic [31:0] digs, input int nd);
        for (int i = 0; i < nd; i++) press(digs[4*(nd-1-i) +: 4]);
        press(4'hA);
    endtask

    task automatic log_txn(input string kind);
        n_txn++;
        $display("txn %0d %-10s on=%0d exit=%0d entry=%0d puerta=%0d locked=%0d fail=%0d",
                 n_txn, kind, on, exit_pend, entry_pend, puerta_o, locked, fail_cnt);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("rst_on", on, 0);
        check_eq("rst_fail", fail_cnt, 0);
        log_txn("reset");

        // Arm, exit delay, then armed.
        sil_seen = 0;
        enter_seq(32'h1234, 4);
        check_eq("arm_exit_pend", exit_pend, 1);
        log_txn("arm");
        idle(EXIT_CYC, 1'b0);
        check_eq("armed_on", on, 1);
        check_eq("armed_exit_pend", exit_pend, 0);
        check_eq("arm_no_silence", sil_seen, 0);
        log_txn("armed");

        // Door opens, entry delay expires into ALARM, then disarm.
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        check_eq("entry_pend", entry_pend, 1);
        check_eq("entry_puerta", puerta_o, 0);
        idle(ENTRY_CYC, 1'b0);
        check_eq("alarm_puerta", puerta_o, 1);
        log_txn("alarm");
        sil_seen = 0;
        enter_seq(32'h1234, 4);
        check_eq("disarm_on", on, 0);
        check_eq("disarm_silence", silence, 1);
        idle(1, 1'b0);
        check_eq("silence_once", sil_seen, 1);
        log_txn("disarm");

        // ENTER lands on the entry timer==0 cycle.
        enter_seq(32'h1234, 4);
        idle(EXIT_CYC, 1'b0);
        alarm_seen = 1'b0;
        sil_seen = 0;
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        enter_seq(32'h1234, 4);
        check_eq("race_silence", silence, 1);
        check_eq("race_on", on, 0);
        idle(3, 1'b0);
        check_eq("race_no_alarm", alarm_seen, 0);
        check_eq("race_sil_once", sil_seen, 1);
        log_txn("race");

        // Three wrong codes, lockout, ignored code, release.
        enter_seq(32'h9999, 4);
        check_eq("fail1", fail_cnt, 1);
        enter_seq(32'h9999, 4);
        check_eq("fail2", fail_cnt, 2);
        enter_seq(32'h9999, 4);
        check_eq("fail3", fail_cnt, 3);
        check_eq("lock_set", locked, 1);
        log_txn("lockout");
        enter_seq(32'h1234, 4);
        check_eq("lock_ignore", exit_pend, 0);
        idle(LOCK_CYC - 5, 1'b0);
        check_eq("lock_clear", locked, 0);
        check_eq("lock_fail0", fail_cnt, 0);
        enter_seq(32'h1234, 4);
        check_eq("unlock_arm", exit_pend, 1);
        idle(EXIT_CYC, 1'b0);
        enter_seq(32'h1234, 4);
        log_txn("unlocked");

        // Overlong entry, then clear and match.
        enter_seq(32'h12345, 5);
        check_eq("overlong_fail", fail_cnt, 1);
        press(4'h1); press(4'h2); press(4'hB);
        enter_seq(32'h1234, 4);
        check_eq("clear_match", fail_cnt, 0);
        check_eq("clear_exit", exit_pend, 1);
        enter_seq(32'h1234, 4);
        check_eq("cancel_exit", exit_pend, 0);
        check_eq("cancel_silence", silence, 0);
        log_txn("overlong");

        // Reset during exit delay with lockout active.
        enter_seq(32'h1234, 4);
        press(4'h9); press(4'hA); press(4'h9); press(4'hA); press(4'h9); press(4'hA);
        check_eq("pre_rst_locked", locked, 1);
        check_eq("pre_rst_exit", exit_pend, 1);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_exit", exit_pend, 0);
        check_eq("rst_silence", silence, 0);
        press(4'h1); press(4'h2);
        cycle(1'b1, 1'b0, 4'h0, 1'b0);
        enter_seq(32'h1234, 4);
        check_eq("rst_buf_empty", exit_pend, 1);
        enter_seq(32'h1234, 4);
        log_txn("rst_mid");

        // Random transactions.
        for (int t = 0; t < 160; t++) begin
            int kind;
            kind = $urandom_range(0, 99);
            if (kind < 30) begin
                enter_seq(32'h1234, 4);
                log_txn("code");
            end else if (kind < 50) begin
                int nd;
                logic [31:0] d;
                nd = $urandom_range(1, 6);
                d = '0;
                for (int i = 0; i < nd; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
                enter_seq(d, nd);
                log_txn("wrong");
            end else if (kind < 60) begin
                press(4'($urandom_range(10, 15)));
                log_txn("ctrl_key");
            end else if (kind < 72) begin
                cycle(1'b0, 1'b0, 4'h0, 1'b1);
                log_txn("door");
            end else if (kind < 98) begin
                idle($urandom_range(1, 12), 1'($urandom_range(0, 3) == 0));
                log_txn("idle");
            end else begin
                cycle(1'b1, 1'b0, 4'h0, 1'($urandom_range(0, 1)));
                log_txn("rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
